// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared BCD types, limits and digit helpers for the time-of-day core
package clock_pkg;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t SEC_MAX  = 8'h59;
  localparam bcd2_t MIN_MAX  = 8'h59;
  localparam bcd2_t HOUR_MAX = 8'h23;

  // Two-digit BCD increment that wraps to 00 after max.
  function automatic bcd2_t bcd_inc(input bcd2_t v, input bcd2_t max);
    bcd2_t r;
    if (v == max) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Maps internal 00..23 hour to the 12,01..11 display form.
  function automatic bcd2_t hour_to_12h(input bcd2_t h);
    logic [4:0] bin;
    logic [4:0] b12;
    bcd2_t      r;
    bin = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
    if (bin == 5'd0) begin
      b12 = 5'd12;
    end else if (bin > 5'd12) begin
      b12 = bin - 5'd12;
    end else begin
      b12 = bin;
    end
    if (b12 >= 5'd10) begin
      r = {4'd1, 4'(b12 - 5'd10)};
    end else begin
      r = {4'd0, b12[3:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/clock_time_counter_if.sv
// rtl/clock_time_counter_if.sv - control pulses in and BCD time out of the time-of-day core
interface clock_time_counter_if;
  import clock_pkg::*;

  logic  i_Run;
  logic  i_Set_Min;
  logic  i_Set_Hour;
  bcd2_t o_Hour_Bcd;
  bcd2_t o_Min_Bcd;
  bcd2_t o_Sec_Bcd;
  logic  o_Sec_Tick;
  logic  o_Pm;

  modport master (
    output i_Run, i_Set_Min, i_Set_Hour,
    input  o_Hour_Bcd, o_Min_Bcd, o_Sec_Bcd, o_Sec_Tick, o_Pm
  );

  modport slave (
    input  i_Run, i_Set_Min, i_Set_Hour,
    output o_Hour_Bcd, o_Min_Bcd, o_Sec_Bcd, o_Sec_Tick, o_Pm
  );

endinterface

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter 00..MAX with clear priority and at-max flag
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter bcd2_t MAX = 8'h59
) (
  input  logic  i_Clk,
  input  logic  i_Rst_n,
  input  logic  i_Inc,
  input  logic  i_Clr,
  output bcd2_t o_Value,
  output logic  o_Wrap
);

  bcd2_t r_value;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_value <= 8'h00;
    end else if (i_Clr) begin
      r_value <= 8'h00;
    end else if (i_Inc) begin
      r_value <= bcd_inc(r_value, MAX);
    end
  end

  // High while the next increment rolls over; callers gate it into a carry.
  assign o_Wrap  = (r_value == MAX);
  assign o_Value = r_value;

endmodule

// File: rtl/clock_time_counter.sv
// rtl/clock_time_counter.sv - 1 Hz prescaler plus BCD hh:mm:ss with set keys; CLOCK_12H_EN selects 12-hour display
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 27_000_000
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  clock_time_counter_if.slave  bus
);

  localparam int             PW = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0]  TC = PW'(CLK_FREQ_HZ - 1);

  logic [PW-1:0] r_presc;
  logic          r_tick;

  logic  w_tc;
  logic  w_tick_ev;
  logic  w_min_inc;
  logic  w_hour_inc;
  logic  w_sec_wrap;
  logic  w_min_wrap;
  logic  w_hour_wrap;
  bcd2_t w_sec;
  bcd2_t w_min;
  bcd2_t w_hour;

  assign w_tc      = bus.i_Run && (r_presc == TC);
  // A minute set restarts the second, so a coincident tick is dropped.
  assign w_tick_ev = w_tc && !bus.i_Set_Min;
  assign w_min_inc = bus.i_Set_Min || (w_tick_ev && w_sec_wrap);
  // OR rather than add: a set key and a carry in the same cycle advance once.
  assign w_hour_inc = bus.i_Set_Hour || (w_tick_ev && w_sec_wrap && w_min_wrap);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_tick_ev;
      if (bus.i_Set_Min) begin
        r_presc <= '0;
      end else if (bus.i_Run) begin
        r_presc <= w_tc ? '0 : r_presc + PW'(1);
      end
    end
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Inc   (w_tick_ev),
    .i_Clr   (bus.i_Set_Min),
    .o_Value (w_sec),
    .o_Wrap  (w_sec_wrap)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Inc   (w_min_inc),
    .i_Clr   (1'b0),
    .o_Value (w_min),
    .o_Wrap  (w_min_wrap)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Inc   (w_hour_inc),
    .i_Clr   (1'b0),
    .o_Value (w_hour),
    .o_Wrap  (w_hour_wrap)
  );

  // The day rollover has no consumer downstream.
  logic w_unused_day_wrap;
  assign w_unused_day_wrap = w_hour_wrap;

  assign bus.o_Min_Bcd  = w_min;
  assign bus.o_Sec_Bcd  = w_sec;
  assign bus.o_Sec_Tick = r_tick;

`ifdef CLOCK_12H_EN
  bcd2_t r_hour_12;
  logic  r_pm;
  bcd2_t w_hour_next;

  assign w_hour_next = bcd_inc(w_hour, HOUR_MAX);

  // Display registers load from the next hour so they change on the same edge.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_hour_12 <= 8'h12;
      r_pm      <= 1'b0;
    end else if (w_hour_inc) begin
      r_hour_12 <= hour_to_12h(w_hour_next);
      r_pm      <= (w_hour_next >= 8'h12);
    end
  end

  assign bus.o_Hour_Bcd = r_hour_12;
  assign bus.o_Pm       = r_pm;
`else
  assign bus.o_Hour_Bcd = w_hour;
  assign bus.o_Pm       = 1'b0;
`endif

endmodule

// File: tb/tb_clock_time_counter.sv
// tb/tb_clock_time_counter.sv - randomized and directed bench for clock_time_counter with CLK_FREQ_HZ=4
module tb_clock_time_counter;
  import clock_pkg::*;

  localparam int F = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clock_time_counter_if bus ();

  clock_time_counter #(.CLK_FREQ_HZ(F)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  int   m_presc, m_h, m_m, m_s;
  logic m_tick;

  wire [25:0] obs = {bus.o_Hour_Bcd, bus.o_Min_Bcd, bus.o_Sec_Bcd, bus.o_Sec_Tick, bus.o_Pm};

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic [8:0] hour_disp(input int h);
`ifdef CLOCK_12H_EN
    return {to_bcd((h % 12 == 0) ? 12 : h % 12), (h >= 12)};
`else
    return {to_bcd(h), 1'b0};
`endif
  endfunction

  function automatic logic [25:0] model_vec();
    logic [8:0] hd;
    hd = hour_disp(m_h);
    return {hd[8:1], to_bcd(m_m), to_bcd(m_s), m_tick, hd[0]};
  endfunction

  function automatic logic [25:0] time_vec(input int h, input int m, input int s, input logic t);
    logic [8:0] hd;
    hd = hour_disp(h);
    return {hd[8:1], to_bcd(m), to_bcd(s), t, hd[0]};
  endfunction

  task automatic model_reset();
    m_presc = 0; m_h = 0; m_m = 0; m_s = 0; m_tick = 1'b0;
  endtask

  task automatic model_step(input logic run, input logic smin, input logic shour);
    logic tc, tick, carry_h;
    tc = run && (m_presc == F - 1);
    tick = tc && !smin;
    carry_h = 1'b0;
    if (smin) m_presc = 0;
    else if (run) m_presc = (m_presc + 1) % F;
    if (smin) begin
      m_m = (m_m + 1) % 60;
      m_s = 0;
    end else if (tick) begin
      m_s = m_s + 1;
      if (m_s == 60) begin
        m_s = 0;
        m_m = m_m + 1;
        if (m_m == 60) begin
          m_m = 0;
          carry_h = 1'b1;
        end
      end
    end
    if (shour || carry_h) m_h = (m_h + 1) % 24;
    m_tick = tick;
  endtask

  task automatic cyc(input logic run, input logic smin, input logic shour);
    bus.i_Run = run; bus.i_Set_Min = smin; bus.i_Set_Hour = shour;
    @(posedge clk);
    model_step(run, smin, shour);
    #1;
  endtask

  task automatic test_reset();
    bus.i_Run = 1'b0; bus.i_Set_Min = 1'b0; bus.i_Set_Hour = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    if (obs !== time_vec(0, 0, 0, 1'b0)) begin
      errors++; $display("FAIL reset act=%h exp=%h", obs, time_vec(0, 0, 0, 1'b0));
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_count();
    int nticks, last;
    nticks = 0; last = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (obs !== model_vec()) begin
        errors++; $display("FAIL count_cyc%0d act=%h exp=%h", i, obs, model_vec());
      end
      checks++;
      if (bus.o_Sec_Tick === 1'b1) begin
        if (i - last != F) begin
          errors++; $display("FAIL tick_spacing act=%0d exp=%0d", i - last, F);
        end
        checks++;
        last = i; nticks++;
      end
    end
    if (nticks != 10) begin
      errors++; $display("FAIL tick_count act=%0d exp=10", nticks);
    end
    checks++;
    if (bus.o_Sec_Bcd !== 8'h10) begin
      errors++; $display("FAIL sec_after_40 act=%h exp=10", bus.o_Sec_Bcd);
    end
    checks++;
  endtask

  task automatic test_wrap();
    int nticks;
    for (int i = 0; i < 23; i++) cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 59; i++) cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 59 * F; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (obs !== model_vec()) begin
        errors++; $display("FAIL wrap_run%0d act=%h exp=%h", i, obs, model_vec());
      end
      checks++;
    end
    if (obs !== time_vec(23, 59, 59, 1'b1)) begin
      errors++; $display("FAIL preload_235959 act=%h exp=%h", obs, time_vec(23, 59, 59, 1'b1));
    end
    checks++;
    nticks = 0;
    for (int i = 0; i < F; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (bus.o_Sec_Tick === 1'b1) nticks++;
    end
    if (obs !== time_vec(0, 0, 0, 1'b1) || nticks != 1) begin
      errors++; $display("FAIL day_wrap act=%h ticks=%0d exp=%h ticks=1", obs, nticks, time_vec(0, 0, 0, 1'b1));
    end
    checks++;
  endtask

  task automatic test_pause();
    logic [25:0] held;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    held = time_vec(0, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (obs !== held) begin
        errors++; $display("FAIL pause%0d act=%h exp=%h", i, obs, held);
      end
      checks++;
    end
    cyc(1'b1, 1'b0, 1'b0);
    if (bus.o_Sec_Tick !== 1'b0) begin
      errors++; $display("FAIL resume_early act=%b exp=0", bus.o_Sec_Tick);
    end
    checks++;
    cyc(1'b1, 1'b0, 1'b0);
    if (obs !== time_vec(0, 0, 1, 1'b1)) begin
      errors++; $display("FAIL resume_tick act=%h exp=%h", obs, time_vec(0, 0, 1, 1'b1));
    end
    checks++;
  endtask

  task automatic test_set_min();
    for (int i = 0; i < 59; i++) cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 30 * F; i++) cyc(1'b1, 1'b0, 1'b0);
    if (obs !== time_vec(0, 59, 30, 1'b1)) begin
      errors++; $display("FAIL at_005930 act=%h exp=%h", obs, time_vec(0, 59, 30, 1'b1));
    end
    checks++;
    cyc(1'b1, 1'b1, 1'b0);
    if (obs !== time_vec(0, 0, 0, 1'b0)) begin
      errors++; $display("FAIL set_min_wrap act=%h exp=%h", obs, time_vec(0, 0, 0, 1'b0));
    end
    checks++;
    for (int i = 1; i <= F; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (bus.o_Sec_Tick !== (i == F)) begin
        errors++; $display("FAIL set_min_tick%0d act=%b exp=%b", i, bus.o_Sec_Tick, (i == F));
      end
      checks++;
    end
  endtask

  task automatic test_set_hour_carry();
    for (int i = 0; i < 59; i++) cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 59 * F; i++) cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < F - 1; i++) cyc(1'b1, 1'b0, 1'b0);
    if (obs !== time_vec(0, 59, 59, 1'b0)) begin
      errors++; $display("FAIL at_005959 act=%h exp=%h", obs, time_vec(0, 59, 59, 1'b0));
    end
    checks++;
    cyc(1'b1, 1'b0, 1'b1);
    if (obs !== time_vec(1, 0, 0, 1'b1)) begin
      errors++; $display("FAIL hour_once act=%h exp=%h", obs, time_vec(1, 0, 0, 1'b1));
    end
    checks++;
    for (int i = 0; i < 24; i++) cyc(1'b0, 1'b0, 1'b1);
    if (obs !== time_vec(1, 0, 0, 1'b0)) begin
      errors++; $display("FAIL hour_x24 act=%h exp=%h", obs, time_vec(1, 0, 0, 1'b0));
    end
    checks++;
  endtask

  task automatic test_random();
    logic run, smin, shour;
    for (int i = 0; i < 1500; i++) begin
      run   = ($urandom % 8) != 0;
      smin  = ($urandom % 25) == 0;
      shour = ($urandom % 20) == 0;
      cyc(run, smin, shour);
      if (obs !== model_vec()) begin
        errors++; $display("FAIL random%0d act=%h exp=%h", i, obs, model_vec());
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    if (obs !== time_vec(0, 0, 0, 1'b0)) begin
      errors++; $display("FAIL async_reset act=%h exp=%h", obs, time_vec(0, 0, 0, 1'b0));
    end
    checks++;
    bus.i_Run = 1'b1;
    @(posedge clk); #1;
    if (obs !== time_vec(0, 0, 0, 1'b0)) begin
      errors++; $display("FAIL reset_held act=%h exp=%h", obs, time_vec(0, 0, 0, 1'b0));
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= F; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (obs !== model_vec() || bus.o_Sec_Tick !== (i == F)) begin
        errors++; $display("FAIL post_reset%0d act=%h exp=%h", i, obs, model_vec());
      end
      checks++;
    end
  endtask

`ifdef CLOCK_12H_EN
  task automatic test_12h();
    test_reset();
    if (bus.o_Hour_Bcd !== 8'h12 || bus.o_Pm !== 1'b0) begin
      errors++; $display("FAIL h12_reset act=%h/%b exp=12/0", bus.o_Hour_Bcd, bus.o_Pm);
    end
    checks++;
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b1);
    if (bus.o_Hour_Bcd !== 8'h12 || bus.o_Pm !== 1'b1) begin
      errors++; $display("FAIL h12_pm act=%h/%b exp=12/1", bus.o_Hour_Bcd, bus.o_Pm);
    end
    checks++;
  endtask
`endif

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_pause();
    test_set_min();
    test_set_hour_carry();
    test_random();
    test_reset_mid();
`ifdef CLOCK_12H_EN
    test_12h();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
